cfu_cmd_driver: RTL and testbench

- Initiator for the CFU cmd/rsp protocol: turns high-level buffer/matrix requests into ordered CFU command sequences and reports completion upstream.
- Sits on the host side, driving the accelerator's cmd_* inputs and consuming its rsp_* outputs.
- Used as the bench/SoC-side driver for loading buffers A/B, launching multiply and reading buffer C.
- Exactly one CFU command outstanding at any time.

---
 rtl/cfu_cmd_driver_pkg.sv | 29 ++
 rtl/cfu_cmd_driver_encoder.sv | 60 ++++++
 rtl/cfu_cmd_driver.sv | 170 +++++++++++++++++
 tb/tb_cfu_cmd_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_cmd_driver_pkg.sv
// rtl/cfu_cmd_driver_pkg.sv - shared encodings for the CFU command driver
// Request ops, CFU function codes, the write acknowledge word and FSM states.
package cfu_cmd_driver_pkg;

  typedef enum logic [1:0] {
    OP_WRITE_A = 2'd0,
    OP_WRITE_B = 2'd1,
    OP_MULT    = 2'd2,
    OP_READ_C  = 2'd3
  } req_op_e;

  localparam logic [2:0] F3_MULT  = 3'd0;
  localparam logic [2:0] F3_WRITE = 3'd1;
  localparam logic [2:0] F3_READ  = 3'd2;
  localparam logic [2:0] F3_TEMP  = 3'd3;

  localparam logic [6:0] FUNC7_IDX = 7'd1;
  localparam logic [6:0] FUNC7_B   = 7'd1;

  localparam logic [31:0] DONE_ACK = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE
  } state_e;

endpackage

// File: rtl/cfu_cmd_driver_encoder.sv
// rtl/cfu_cmd_driver_encoder.sv - maps (op, step, latched request) to one CFU command
// Purely combinational; last_step_o flags the final command of the sequence.
module cfu_cmd_encoder
  import cfu_cmd_driver_pkg::*;
(
  input  req_op_e        op_i,
  input  logic [1:0]     step_i,
  input  logic [13:0]    addr_i,
  input  logic [3:0]     word_i,
  input  logic [127:0]   data_i,
  input  logic           offset_i,
  input  logic [9:0]     k_i,
  input  logic [10:0]    m_i,
  input  logic [8:0]     n_i,
  output logic [9:0]     function_id_o,
  output logic [31:0]    inputs_0_o,
  output logic [31:0]    inputs_1_o,
  output logic           last_step_o
);

  always_comb begin
    function_id_o = '0;
    inputs_0_o    = '0;
    inputs_1_o    = '0;
    last_step_o   = 1'b1;
    case (op_i)
      OP_WRITE_A, OP_WRITE_B: begin
        // index, upper half into temp, lower half plus commit to A or B
        last_step_o = (step_i == 2'd2);
        case (step_i)
          2'd0: begin
            function_id_o = {FUNC7_IDX, F3_TEMP};
            inputs_0_o    = {18'b0, addr_i};
          end
          2'd1: begin
            function_id_o = {7'd0, F3_TEMP};
            inputs_0_o    = data_i[127:96];
            inputs_1_o    = data_i[95:64];
          end
          default: begin
            function_id_o = {(op_i == OP_WRITE_B) ? FUNC7_B : 7'd0, F3_WRITE};
            inputs_0_o    = data_i[63:32];
            inputs_1_o    = data_i[31:0];
          end
        endcase
      end
      OP_MULT: begin
        function_id_o = {6'b0, offset_i, F3_MULT};
        inputs_0_o    = {22'b0, k_i};
        inputs_1_o    = {5'b0, m_i, 7'b0, n_i};
      end
      default: begin
        function_id_o = {7'd0, F3_READ};
        inputs_0_o    = {21'b0, addr_i[10:0]};
        inputs_1_o    = {28'b0, word_i};
      end
    endcase
  end

endmodule

// File: rtl/cfu_cmd_driver.sv
// rtl/cfu_cmd_driver.sv - single-outstanding CFU command sequencer for buffer/matrix requests
// Optional response watchdog: CFU_DRV_TIMEOUT_EN.
module cfu_cmd_driver
  import cfu_cmd_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [13:0]    req_addr,
  input  logic [3:0]     req_word,
  input  logic [127:0]   req_data,
  input  logic           req_offset,
  input  logic [9:0]     req_K,
  input  logic [10:0]    req_M,
  input  logic [8:0]     req_N,
  output logic           done_valid,
  output logic [31:0]    done_data,
  output logic           done_err,
  output logic           cmd_valid,
  input  logic           cmd_ready,
  output logic [9:0]     cmd_payload_function_id,
  output logic [31:0]    cmd_payload_inputs_0,
  output logic [31:0]    cmd_payload_inputs_1,
  input  logic           rsp_valid,
  output logic           rsp_ready,
  input  logic [31:0]    rsp_payload_outputs_0
);

  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          latch;

  req_op_e       op_q;
  logic [13:0]   addr_q;
  logic [3:0]    word_q;
  logic [127:0]  data_q;
  logic          offset_q;
  logic [9:0]    k_q;
  logic [10:0]   m_q;
  logic [8:0]    n_q;

  logic [9:0]    enc_fid;
  logic [31:0]   enc_in0, enc_in1;
  logic          last_step;

`ifdef CFU_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  cfu_cmd_encoder u_enc (
    .op_i          (op_q),
    .step_i        (step_q),
    .addr_i        (addr_q),
    .word_i        (word_q),
    .data_i        (data_q),
    .offset_i      (offset_q),
    .k_i           (k_q),
    .m_i           (m_q),
    .n_i           (n_q),
    .function_id_o (enc_fid),
    .inputs_0_o    (enc_in0),
    .inputs_1_o    (enc_in1),
    .last_step_o   (last_step)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    latch   = 1'b0;
`ifdef CFU_DRV_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          latch   = 1'b1;
          step_d  = 2'd0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_WAIT_RSP;
`ifdef CFU_DRV_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_WAIT_RSP: begin
`ifdef CFU_DRV_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
`endif
        // a bad acknowledge is remembered but the sequence still runs to the end
        if (rsp_valid) begin
          if (op_q == OP_READ_C) rdata_d = rsp_payload_outputs_0;
          else if (rsp_payload_outputs_0 != DONE_ACK) err_d = 1'b1;
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
`ifdef CFU_DRV_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef CFU_DRV_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef CFU_DRV_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      op_q     <= req_op_e'(req_op);
      addr_q   <= req_addr;
      word_q   <= req_word;
      data_q   <= req_data;
      offset_q <= req_offset;
      k_q      <= req_K;
      m_q      <= req_M;
      n_q      <= req_N;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign cmd_valid  = (state_q == S_ISSUE);
  assign rsp_ready  = (state_q == S_WAIT_RSP);
  assign done_valid = (state_q == S_DONE);
  assign done_data  = done_valid ? rdata_q : '0;
  assign done_err   = done_valid & err_q;

  assign cmd_payload_function_id = cmd_valid ? enc_fid : '0;
  assign cmd_payload_inputs_0    = cmd_valid ? enc_in0 : '0;
  assign cmd_payload_inputs_1    = cmd_valid ? enc_in1 : '0;

endmodule

// File: tb/tb_cfu_cmd_driver.sv
// tb/tb_cfu_cmd_driver.sv - scoreboard bench for cfu_cmd_driver
// Stimulus pushes expected commands/completions; a negedge monitor pops and compares.
module tb_cfu_cmd_driver;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [13:0]  req_addr;
  logic [3:0]   req_word;
  logic [127:0] req_data;
  logic         req_offset;
  logic [9:0]   req_K;
  logic [10:0]  req_M;
  logic [8:0]   req_N;
  logic         done_valid, done_err;
  logic [31:0]  done_data;
  logic         cmd_valid, cmd_ready;
  logic [9:0]   cmd_payload_function_id;
  logic [31:0]  cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_payload_outputs_0;

  cfu_cmd_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_op                  (req_op),
    .req_addr                (req_addr),
    .req_word                (req_word),
    .req_data                (req_data),
    .req_offset              (req_offset),
    .req_K                   (req_K),
    .req_M                   (req_M),
    .req_N                   (req_N),
    .done_valid              (done_valid),
    .done_data               (done_data),
    .done_err                (done_err),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [13:0]  addr;
    logic [3:0]   word;
    logic [127:0] data;
    logic         offset;
    logic [9:0]   k;
    logic [10:0]  m;
    logic [8:0]   n;
  } req_t;

  typedef struct packed {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } done_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1);
    cmd_t c;
    c.fid = fid; c.in0 = in0; c.in1 = in1;
    return c;
  endfunction

  // reference: the command list a request must produce
  task automatic model_push(input req_t r);
    case (r.op)
      2'd0, 2'd1: begin
        exp_cmd_q.push_back(mk_cmd(10'h00B, 32'(r.addr), 32'h0));
        exp_cmd_q.push_back(mk_cmd(10'h003, r.data[127:96], r.data[95:64]));
        exp_cmd_q.push_back(mk_cmd((r.op == 2'd1) ? 10'h009 : 10'h001, r.data[63:32], r.data[31:0]));
      end
      2'd2: exp_cmd_q.push_back(mk_cmd(r.offset ? 10'h008 : 10'h000, 32'(r.k),
                                       32'(r.m) * 65536 + 32'(r.n)));
      default: exp_cmd_q.push_back(mk_cmd(10'h002, 32'(r.addr) % 2048, 32'(r.word)));
    endcase
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got fid=%0h expected none", cmd_payload_function_id);
        end else begin
          chk("cmd_fid", cmd_payload_function_id, exp_cmd_q[0].fid);
          chk("cmd_in0", cmd_payload_inputs_0, exp_cmd_q[0].in0);
          chk("cmd_in1", cmd_payload_inputs_1, exp_cmd_q[0].in1);
          if (cmd_ready) void'(exp_cmd_q.pop_front());
        end
      end
      if (done_valid) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done_valid=1 expected 0");
        end else begin
          chk("done_data", done_data, exp_done_q[0].data);
          chk("done_err", done_err, exp_done_q[0].err);
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  function automatic req_t rand_req();
    req_t r;
    r.op = 2'($urandom); r.addr = 14'($urandom); r.word = 4'($urandom);
    r.data = {$urandom, $urandom, $urandom, $urandom};
    r.offset = 1'($urandom); r.k = 10'($urandom); r.m = 11'($urandom); r.n = 9'($urandom);
    return r;
  endfunction

  task automatic drive_fields(input req_t r);
    req_op = r.op; req_addr = r.addr; req_word = r.word; req_data = r.data;
    req_offset = r.offset; req_K = r.k; req_M = r.m; req_N = r.n;
  endtask

  task automatic send_req(input req_t r);
    chk("req_ready_idle", req_ready, 1);
    drive_fields(r);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drive_fields(rand_req());
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_valid) begin
      total++; bad++;
      $display("FAIL cmd_wait_timeout: got cmd_valid=0 expected 1");
    end
  endtask

  // one CFU step as the responder: optional stall with noise, handshake, response
  task automatic do_step(input int stall, input int lat, input logic [31:0] rsp);
    wait_cmd();
    for (int s = 0; s < stall; s++) begin
      drive_fields(rand_req());
      req_valid = 1'b1;
      rsp_valid = 1'b1;
      rsp_payload_outputs_0 = $urandom;
      chk("req_ready_busy", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    chk("rsp_ready_wait", rsp_ready, 1);
    chk("cmd_valid_wait", cmd_valid, 0);
    for (int l = 0; l < lat; l++) begin @(posedge clk); #1; end
    rsp_valid = 1'b1;
    rsp_payload_outputs_0 = rsp;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    rsp_payload_outputs_0 = $urandom;
  endtask

  task automatic run_req(input req_t r, input int stall, input int lat, input int bad_step,
                         input logic [31:0] alt);
    int    n;
    logic  err;
    done_t d;
    n = (r.op < 2'd2) ? 3 : 1;
    err = 1'b0;
    for (int i = 0; i < n; i++)
      if (r.op != 2'd3 && i == bad_step && alt != 32'hFFFF_FFFF) err = 1'b1;
    d.data = (r.op == 2'd3) ? alt : 32'h0;
    d.err = err;
    model_push(r);
    exp_done_q.push_back(d);
    send_req(r);
    for (int i = 0; i < n; i++)
      do_step(stall, lat, (r.op == 2'd3 || i == bad_step) ? alt : 32'hFFFF_FFFF);
    chk("done_latency", done_valid, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   d0;
    reset = 1'b1; req_valid = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    rsp_payload_outputs_0 = '0;
    drive_fields(rand_req());
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_data", done_data, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_fid", cmd_payload_function_id, 0);
    chk("rst_in0", cmd_payload_inputs_0, 0);
    chk("rst_in1", cmd_payload_inputs_1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    r = rand_req(); r.op = 2'd0; r.addr = 14'h0123;
    r.data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    run_req(r, 0, 0, -1, 32'h0);

    r = rand_req(); r.op = 2'd1; r.addr = 14'h0FFF;
    run_req(r, 5, 1, -1, 32'h0);

    r = rand_req(); r.op = 2'd2; r.k = 10'd64; r.m = 11'd300; r.n = 9'd16; r.offset = 1'b1;
    run_req(r, 0, 200, -1, 32'h0);

    r = rand_req(); r.op = 2'd3; r.addr = 14'd5; r.word = 4'd15;
    run_req(r, 0, 0, -1, 32'hDEAD_BEEF);

    r = rand_req(); r.op = 2'd0;
    run_req(r, 0, 0, 1, 32'h0);

    // abort a WRITE_A during its third command
    r = rand_req(); r.op = 2'd0;
    model_push(r);
    send_req(r);
    do_step(0, 0, 32'hFFFF_FFFF);
    do_step(0, 0, 32'hFFFF_FFFF);
    wait_cmd();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_cmd_valid", cmd_valid, 0);
    chk("abort_rsp_ready", rsp_ready, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_done_valid", done_valid, 0);
    exp_cmd_q.delete();
    d0 = done_cnt;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, d0);

    for (int t = 0; t < 40; t++) begin
      r = rand_req();
      run_req(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, $urandom);
    end

`ifdef CFU_DRV_TIMEOUT_EN
    begin
      done_t d;
      r = rand_req(); r.op = 2'd2;
      d.data = 32'h0; d.err = 1'b1;
      model_push(r);
      exp_done_q.push_back(d);
      send_req(r);
      wait_cmd();
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
      chk("tmo_not_yet", done_valid, 0);
      @(posedge clk); #1;
      chk("tmo_done", done_valid, 1);
      @(posedge clk); #1;
    end
`endif

    chk("cmd_queue_empty", exp_cmd_q.size(), 0);
    chk("done_queue_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
